aes_ctr_block_seq: RTL and testbench
====================================

// Module: aes_ctr_block_seq
// PURPOSE
//  Upstream sequencer for the AES-192 CTR encrypt/decrypt core. Accepts a valid/ready stream of
//  128-bit text blocks and drives the core one block at a time: holds key, counter block and
//  text stable, and pulses start with a clean 0->1 edge. Captures the core result on its
//  out_valid edge, increments the counter and returns results on a valid/ready output stream.
// PARAMETERS
//  CTR_WIDTH       32  low bits of the counter block that increment per block (1..128)
//  TIMEOUT_CYCLES  64  max cycles in WAIT_LO+WAIT_HI before err_timeout (>=2)
// PORTS
//  clk            in   1    clock; all logic rising-edge
//  rst_n          in   1    synchronous active-low reset
//  cfg_load       in   1    load cfg_key/cfg_iv; honoured only in IDLE or READY
//  cfg_key        in   192  AES-192 key
//  cfg_iv         in   128  initial counter block (nonce||counter)
//  busy           out  1    high in any state other than IDLE/READY
//  in_valid       in   1    input block valid
//  in_ready       out  1    high only in READY
//  in_data        in   128  plain/cipher text; byte 0 = [127:120]
//  in_last        in   1    marks last block of message
//  out_valid      out  1    result valid (state OUT)
//  out_ready      in   1    downstream accepts result
//  out_data       out  128  text XOR keystream
//  out_last       out  1    copy of accepted in_last
//  core_start     out  1    to core start
//  core_key       out  192  to core key (registered)
//  core_state     out  128  to core state (current counter block)
//  core_p_c_text  out  128  to core p_c_text (registered)
//  core_out       in   128  core out
//  core_out_valid in   1    core out_valid
//  ctr_wrap       out  1    sticky: low CTR_WIDTH bits wrapped all-ones -> 0
//  err_timeout    out  1    sticky: core did not complete in TIMEOUT_CYCLES
// BEHAVIOUR
//  Reset (rst_n=0 at edge): state IDLE; all outputs and data regs 0; applies in any state,
//   mid-block included; partially processed block discarded, core_start forced 0.
//  IDLE: in_ready=0. cfg_load -> latch key, iv into counter, clear ctr_wrap/err_timeout -> READY.
//  READY: in_ready=1. cfg_load takes priority over in_valid (reload, stay READY, block not taken).
//   in_valid=1 -> latch in_data/in_last into core_p_c_text/last_q -> START.
//  START: core_start=1 for exactly one cycle (0 in every other state) -> WAIT_LO.
//  WAIT_LO: wait for core_out_valid=0 (stale valid from prior block ignored) -> WAIT_HI.
//  WAIT_HI: on core_out_valid=1 latch core_out into out_data -> OUT. Same cycle: counter[CTR_WIDTH-1:0]
//   += 1 mod 2^CTR_WIDTH, upper 128-CTR_WIDTH bits unchanged; all-ones->0 sets ctr_wrap.
//  Timeout: cycle count in WAIT_LO+WAIT_HI reaches TIMEOUT_CYCLES -> set err_timeout, drop block,
//   counter unchanged -> IDLE (cfg_load required to resume).
//  OUT: out_valid=1, out_data/out_last stable until out_ready=1 -> READY; out_ready ignored elsewhere.
//  Latency in_valid accept -> out_valid: 3 cycles + core latency. One block in flight; in_ready=0
//   while busy. cfg_load in START..OUT ignored. core_state/core_key/core_p_c_text stable START..OUT.
//  Counter persists across messages; in_last does not reset it (reload via cfg_load).
// CONFIGURATION
//  AES_CTR_SEQ_PARTIAL_EN defined: adds in_nbytes (in,5) and out_nbytes (out,5), latched with
//   in_data. On in_last=1, out_data bytes k>=in_nbytes zeroed (k=0 at [127:120]); in_nbytes 0 or >16
//   treated as 16; out_nbytes = effective count. in_nbytes ignored on non-last blocks (out_nbytes=16).
//  Undefined: ports absent, full 16-byte blocks always.
// TESTING
//  1 Reset, cfg_load iv=0, key=0, one block -> core_start single pulse; out_data=in_data^core_out;
//    core_state counter=0 -> 1.
//  2 iv low32=FFFFFFFF, CTR_WIDTH=32, two blocks -> 2nd core_state low32=0, upper 96 unchanged, ctr_wrap=1.
//  3 Core model holds out_valid high between blocks -> no premature capture; WAIT_LO seen each block.
//  4 out_ready held 0 for 10 cycles -> out_valid/out_data stable, in_ready=0, no 2nd core_start.
//  5 Core never asserts out_valid -> err_timeout=1 after 64 cycles, IDLE, in_ready=0 until cfg_load.
//  6 rst_n=0 in WAIT_HI -> next cycle all outputs 0; PARTIAL_EN: in_nbytes=5 on last -> bytes 5..15 = 0.

Source files
------------

// File: rtl/aes_ctr_block_seq_if.sv
// aes_ctr_block_seq_if
//   Text-block stream bundle for aes_ctr_block_seq.
//   Input side : in_valid/in_ready handshake carrying in_data (byte 0 = [127:120]) and in_last.
//   Output side: out_valid/out_ready handshake carrying out_data and out_last.
//   With AES_CTR_SEQ_PARTIAL_EN defined, in_nbytes/out_nbytes (valid byte count) are added.
//   Modports: master = stream producer/consumer (testbench or upstream logic),
//             slave  = the sequencer.
interface aes_ctr_block_seq_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         in_last;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         out_last;
`ifdef AES_CTR_SEQ_PARTIAL_EN
    logic [4:0]   in_nbytes;
    logic [4:0]   out_nbytes;

    modport master (
        output in_valid, in_data, in_last, in_nbytes, out_ready,
        input  in_ready, out_valid, out_data, out_last, out_nbytes
    );
    modport slave (
        input  in_valid, in_data, in_last, in_nbytes, out_ready,
        output in_ready, out_valid, out_data, out_last, out_nbytes
    );
`else
    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );
    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
`endif
endinterface

// File: rtl/aes_ctr_block_seq.sv
// aes_ctr_block_seq
//   Upstream sequencer for an AES-192 CTR core. Takes one 128-bit text block at a time from
//   the input stream, presents key / counter block / text to the core, pulses core_start,
//   captures the core result on a fresh core_out_valid edge, XORs it with the text, bumps the
//   low CTR_WIDTH counter bits and offers the result on the output stream.
// Ports
//   clk, rst_n            clock, synchronous active-low reset
//   cfg_load/key/iv       key and initial counter block load (IDLE or READY only)
//   busy                  high outside IDLE/READY
//   io (slave)            in_* / out_* valid-ready text streams
//   core_start/key/state/p_c_text, core_out/core_out_valid   core handshake
//   ctr_wrap              sticky: counter low bits wrapped from all-ones to zero
//   err_timeout           sticky: core did not finish within TIMEOUT_CYCLES
// Configuration macro
//   AES_CTR_SEQ_PARTIAL_EN: adds in_nbytes/out_nbytes; trailing bytes of a last block beyond
//   in_nbytes are zeroed in out_data.
module aes_ctr_block_seq #(
    parameter int unsigned CTR_WIDTH      = 32,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cfg_load,
    input  logic [191:0]         cfg_key,
    input  logic [127:0]         cfg_iv,
    output logic                 busy,
    aes_ctr_block_seq_if.slave   io,
    output logic                 core_start,
    output logic [191:0]         core_key,
    output logic [127:0]         core_state,
    output logic [127:0]         core_p_c_text,
    input  logic [127:0]         core_out,
    input  logic                 core_out_valid,
    output logic                 ctr_wrap,
    output logic                 err_timeout
);

    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    // Bits of the counter block that take part in the increment; the rest pass through.
    localparam logic [127:0] CTR_MASK =
        (CTR_WIDTH >= 128) ? '1 : ((128'd1 << CTR_WIDTH) - 128'd1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READY,
        S_START,
        S_WAIT_LO,
        S_WAIT_HI,
        S_OUT
    } state_t;

    state_t             state;
    logic               last_q;
    logic [TMO_W-1:0]   tmo_cnt;
    logic [127:0]       ctr_next;
    logic               ctr_at_max;
    logic               tmo_hit;
    logic [127:0]       result;
`ifdef AES_CTR_SEQ_PARTIAL_EN
    logic [4:0]         eff_nbytes;
    logic [127:0]       keep_mask;
`endif

    always_comb begin
        ctr_next   = (core_state & ~CTR_MASK) | ((core_state + 128'd1) & CTR_MASK);
        ctr_at_max = ((core_state & CTR_MASK) == CTR_MASK);
        tmo_hit    = (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`ifdef AES_CTR_SEQ_PARTIAL_EN
        eff_nbytes = (io.in_last && (io.in_nbytes != 5'd0) && (io.in_nbytes <= 5'd16))
                     ? io.in_nbytes : 5'd16;
        // Byte 0 sits at the top, so keep the upper out_nbytes bytes; a count of 16 shifts
        // everything out and leaves the mask all-ones.
        keep_mask  = ~({128{1'b1}} >> {io.out_nbytes, 3'b000});
        result     = (core_out ^ core_p_c_text) & keep_mask;
`else
        result     = core_out ^ core_p_c_text;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            busy          <= 1'b0;
            io.in_ready   <= 1'b0;
            io.out_valid  <= 1'b0;
            io.out_data   <= '0;
            io.out_last   <= 1'b0;
            core_start    <= 1'b0;
            core_key      <= '0;
            core_state    <= '0;
            core_p_c_text <= '0;
            ctr_wrap      <= 1'b0;
            err_timeout   <= 1'b0;
            last_q        <= 1'b0;
            tmo_cnt       <= '0;
`ifdef AES_CTR_SEQ_PARTIAL_EN
            io.out_nbytes <= '0;
`endif
        end else begin
            case (state)
                S_IDLE, S_READY: begin
                    if (cfg_load) begin
                        core_key    <= cfg_key;
                        core_state  <= cfg_iv;
                        ctr_wrap    <= 1'b0;
                        err_timeout <= 1'b0;
                        io.in_ready <= 1'b1;
                        state       <= S_READY;
                    end else if ((state == S_READY) && io.in_valid) begin
                        core_p_c_text <= io.in_data;
                        last_q        <= io.in_last;
`ifdef AES_CTR_SEQ_PARTIAL_EN
                        io.out_nbytes <= eff_nbytes;
`endif
                        io.in_ready   <= 1'b0;
                        busy          <= 1'b1;
                        core_start    <= 1'b1;
                        state         <= S_START;
                    end
                end
                S_START: begin
                    core_start <= 1'b0;
                    tmo_cnt    <= '0;
                    state      <= S_WAIT_LO;
                end
                S_WAIT_LO: begin
                    // A valid still high from the previous block must drop before a result
                    // is believed.
                    if (tmo_hit) begin
                        err_timeout <= 1'b1;
                        busy        <= 1'b0;
                        state       <= S_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                        if (!core_out_valid) state <= S_WAIT_HI;
                    end
                end
                S_WAIT_HI: begin
                    if (core_out_valid) begin
                        io.out_data  <= result;
                        io.out_last  <= last_q;
                        io.out_valid <= 1'b1;
                        core_state   <= ctr_next;
                        if (ctr_at_max) ctr_wrap <= 1'b1;
                        state        <= S_OUT;
                    end else if (tmo_hit) begin
                        err_timeout <= 1'b1;
                        busy        <= 1'b0;
                        state       <= S_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end
                S_OUT: begin
                    if (io.out_ready) begin
                        io.out_valid <= 1'b0;
                        busy         <= 1'b0;
                        io.in_ready  <= 1'b1;
                        state        <= S_READY;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_ctr_block_seq.sv
// tb_aes_ctr_block_seq
//   Scoreboard bench for aes_ctr_block_seq with a behavioural core model (configurable latency,
//   stale-valid hold and never-complete modes). Build with AES_CTR_SEQ_PARTIAL_EN defined to
//   also exercise the partial last block path.
`timescale 1ns/1ps
module tb_aes_ctr_block_seq;
    localparam int unsigned TMO = 64;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         cfg_load = 1'b0;
    logic [191:0] cfg_key = '0;
    logic [127:0] cfg_iv = '0;
    logic         busy;
    logic         core_start;
    logic [191:0] core_key;
    logic [127:0] core_state;
    logic [127:0] core_p_c_text;
    logic [127:0] core_out;
    logic         core_out_valid;
    logic         ctr_wrap;
    logic         err_timeout;

    aes_ctr_block_seq_if io();

    aes_ctr_block_seq #(.CTR_WIDTH(32), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_load(cfg_load), .cfg_key(cfg_key), .cfg_iv(cfg_iv),
        .busy(busy), .io(io), .core_start(core_start), .core_key(core_key),
        .core_state(core_state), .core_p_c_text(core_p_c_text), .core_out(core_out),
        .core_out_valid(core_out_valid), .ctr_wrap(ctr_wrap), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [191:0] got, input logic [191:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] ks(input logic [127:0] s, input logic [191:0] k);
        return {s[95:0], s[127:96]} ^ k[191:64] ^ {k[63:0], ~k[63:0]}
               ^ 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
    endfunction

    // Core model
    int unsigned lat = 4;
    bit          hold_mode = 1'b0;
    bit          never_mode = 1'b0;
    int unsigned dly = 0;
    bit          pend = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            core_out_valid <= 1'b0;
            core_out       <= '0;
            pend           <= 1'b0;
            dly            <= 0;
        end else if (core_start) begin
            pend <= 1'b1;
            dly  <= lat;
            if (!hold_mode) core_out_valid <= 1'b0;
        end else if (pend) begin
            if (dly == 2) core_out_valid <= 1'b0;
            if (dly != 0) dly <= dly - 1;
            else if (!never_mode) begin
                core_out_valid <= 1'b1;
                core_out       <= ks(core_state, core_key);
                pend           <= 1'b0;
            end
        end
    end

    // Scoreboard
    typedef struct {
        logic [127:0] data;
        logic         last;
        logic [4:0]   nb;
    } exp_t;

    exp_t         sbq[$];
    exp_t         mon_e;
    logic [127:0] mdl_ctr = '0;
    logic [191:0] mdl_key = '0;
    int           start_cnt = 0;

    always @(negedge clk) if (core_start) start_cnt++;

    always @(negedge clk) begin
        if (rst_n && io.out_valid && io.out_ready) begin
            if (sbq.size() == 0) check("sb_empty", 1, 0);
            else begin
                mon_e = sbq.pop_front();
                check("out_data", io.out_data, mon_e.data);
                check("out_last", io.out_last, mon_e.last);
`ifdef AES_CTR_SEQ_PARTIAL_EN
                check("out_nbytes", io.out_nbytes, mon_e.nb);
`endif
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [191:0] k, input logic [127:0] iv);
        tick();
        cfg_load = 1'b1;
        cfg_key  = k;
        cfg_iv   = iv;
        tick();
        cfg_load = 1'b0;
        mdl_key  = k;
        mdl_ctr  = iv;
    endtask

    task automatic send(input logic [127:0] d, input logic l, input logic [4:0] nb,
                        input bit expect_out);
        int unsigned n = 0;
        exp_t e;
        logic [4:0] eff;
        tick();
        io.in_valid = 1'b1;
        io.in_data  = d;
        io.in_last  = l;
`ifdef AES_CTR_SEQ_PARTIAL_EN
        io.in_nbytes = nb;
        eff = (l && nb >= 5'd1 && nb <= 5'd16) ? nb : 5'd16;
`else
        eff = 5'd16;
`endif
        @(negedge clk);
        while (!io.in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("accept_bound", (n < 300) ? 1 : 0, 1);
        e.data = d ^ ks(mdl_ctr, mdl_key);
        for (int k = 0; k < 16; k++)
            if (k >= int'(eff)) e.data[127-8*k -: 8] = 8'h00;
        e.last = l;
        e.nb   = eff;
        if (expect_out) begin
            sbq.push_back(e);
            mdl_ctr = {mdl_ctr[127:32], mdl_ctr[31:0] + 32'd1};
        end
        tick();
        io.in_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int unsigned n = 0;
        while (sbq.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check(tag, sbq.size(), 0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_in_ready"}, io.in_ready, 0);
        check({tag, "_out_valid"}, io.out_valid, 0);
        check({tag, "_out_data"}, io.out_data, 0);
        check({tag, "_out_last"}, io.out_last, 0);
        check({tag, "_core_start"}, core_start, 0);
        check({tag, "_core_key"}, core_key, 0);
        check({tag, "_core_state"}, core_state, 0);
        check({tag, "_core_ptext"}, core_p_c_text, 0);
        check({tag, "_ctr_wrap"}, ctr_wrap, 0);
        check({tag, "_err_timeout"}, err_timeout, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        int sc;
        int unsigned n;
        bit ok;
        logic [127:0] d0;
        logic [127:0] upper_iv;

        io.in_valid  = 1'b0;
        io.in_data   = '0;
        io.in_last   = 1'b0;
        io.out_ready = 1'b1;
`ifdef AES_CTR_SEQ_PARTIAL_EN
        io.in_nbytes = 5'd16;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        tick();
        rst_n = 1'b1;

        // 1: zero key/iv, one block
        load('0, '0);
        @(negedge clk);
        check("t1_in_ready", io.in_ready, 1);
        sc = start_cnt;
        send(128'h0011_2233_4455_6677_8899_aabb_ccdd_eeff, 1'b1, 5'd16, 1'b1);
        drain("t1_drain");
        check("t1_starts", start_cnt - sc, 1);
        check("t1_ctr", core_state, 128'd1);

        // 2: counter wrap in the low 32 bits
        upper_iv = {96'hdead_beef_cafe_f00d_1234_5678, 32'hffff_ffff};
        load({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom}, upper_iv);
        @(negedge clk);
        check("t2_wrap_clear", ctr_wrap, 0);
        send({$urandom, $urandom, $urandom, $urandom}, 1'b0, 5'd16, 1'b1);
        drain("t2_drain1");
        check("t2_ctr_after1", core_state, {96'hdead_beef_cafe_f00d_1234_5678, 32'h0});
        check("t2_wrap", ctr_wrap, 1);
        send({$urandom, $urandom, $urandom, $urandom}, 1'b1, 5'd16, 1'b1);
        drain("t2_drain2");
        check("t2_ctr_after2", core_state, mdl_ctr);

        // 3: core keeps a stale valid high across blocks
        hold_mode = 1'b1;
        lat = 5;
        sc = start_cnt;
        for (int b = 0; b < 3; b++) begin
            send({$urandom, $urandom, $urandom, $urandom}, (b == 2), 5'd16, 1'b1);
            drain("t3_drain");
        end
        check("t3_starts", start_cnt - sc, 3);
        hold_mode = 1'b0;
        lat = 4;

        // 4: downstream backpressure
        tick();
        io.out_ready = 1'b0;
        send({$urandom, $urandom, $urandom, $urandom}, 1'b0, 5'd16, 1'b1);
        n = 0;
        while (!io.out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("t4_out_valid_bound", (n < 100) ? 1 : 0, 1);
        d0 = io.out_data;
        sc = start_cnt;
        ok = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (!io.out_valid || io.out_data !== d0 || io.in_ready || !busy) ok = 1'b0;
        end
        check("t4_hold_stable", ok, 1);
        check("t4_no_start", start_cnt - sc, 0);
        tick();
        io.out_ready = 1'b1;
        drain("t4_drain");

        // 5: core never completes
        never_mode = 1'b1;
        send({$urandom, $urandom, $urandom, $urandom}, 1'b0, 5'd16, 1'b0);
        @(negedge clk);
        check("t5_start", core_start, 1);
        n = 0;
        while (!err_timeout && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("t5_tmo_cycles", n, TMO + 1);
        check("t5_in_ready", io.in_ready, 0);
        check("t5_busy", busy, 0);
        check("t5_ctr_kept", core_state, mdl_ctr);
        repeat (5) @(negedge clk);
        check("t5_in_ready_later", io.in_ready, 0);
        never_mode = 1'b0;
        load(core_key, core_state);
        @(negedge clk);
        check("t5_resume_ready", io.in_ready, 1);
        check("t5_err_clear", err_timeout, 0);
        send({$urandom, $urandom, $urandom, $urandom}, 1'b1, 5'd16, 1'b1);
        drain("t5_drain");

        // 6: reset while waiting on the core
        lat = 20;
        send({$urandom, $urandom, $urandom, $urandom}, 1'b0, 5'd16, 1'b0);
        repeat (4) @(negedge clk);
        check("t6_busy", busy, 1);
        tick();
        rst_n = 1'b0;
        tick();
        check_zero("t6");
        rst_n = 1'b1;
        lat = 4;

`ifdef AES_CTR_SEQ_PARTIAL_EN
        load({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
             {$urandom, $urandom, $urandom, $urandom});
        send({$urandom, $urandom, $urandom, $urandom}, 1'b0, 5'd3, 1'b1);
        send({$urandom, $urandom, $urandom, $urandom}, 1'b1, 5'd5, 1'b1);
        send({$urandom, $urandom, $urandom, $urandom}, 1'b1, 5'd0, 1'b1);
        send({$urandom, $urandom, $urandom, $urandom}, 1'b1, 5'd20, 1'b1);
        drain("partial_drain");
`endif

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
